// File: rtl/scoreboard_register_file.sv
// scoreboard_register_file: 2R/1W register file with r0 = 0 and a per-register busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module scoreboard_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] readRegister1,
    input  logic [ADDR_WIDTH-1:0] readRegister2,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2,
    output logic                  readBusy1,
    output logic                  readBusy2,
    input  logic [ADDR_WIDTH-1:0] writeRegister,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  regWrite,
    input  logic [ADDR_WIDTH-1:0] reserveRegister,
    input  logic                  reserve,
    output logic                  reserveGrant,
    output logic [ADDR_WIDTH:0]   busyCount
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]      busy_q, busy_d;
    logic [ADDR_WIDTH:0]   busy_count_q, busy_count_d;
    logic                  wr_en, same_reg, res_commit, inc, dec;

    assign wr_en        = regWrite & (writeRegister != '0);
    assign same_reg     = wr_en & (writeRegister == reserveRegister);
    assign reserveGrant = reserve & ((reserveRegister == '0) | ~busy_q[reserveRegister] | (regWrite & (writeRegister == reserveRegister)));
    assign res_commit   = reserveGrant & (reserveRegister != '0);
    // A reserve only adds to the count when it flips a clear bit; a write only subtracts when it clears a busy bit that no reserve re-sets.
    assign inc          = res_commit & ~busy_q[reserveRegister];
    assign dec          = wr_en & busy_q[writeRegister] & ~(res_commit & same_reg);
    assign busyCount    = busy_count_q;

    // Next busy vector: write clears first, a committed reserve then sets (reserve wins on a tie).
    always_comb begin
        busy_d = busy_q;
        if (wr_en) busy_d[writeRegister] = 1'b0;
        if (res_commit) busy_d[reserveRegister] = 1'b1;
        busy_count_d = busy_count_q + (ADDR_WIDTH+1)'(inc) - (ADDR_WIDTH+1)'(dec);
    end

    // Storage, scoreboard and counter; r0 is never written so it stays zero and never busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q       <= '{default: '0};
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            if (wr_en) regs_q[writeRegister] <= writeData;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic byp1, byp2;
    assign byp1 = wr_en & (readRegister1 == writeRegister);
    assign byp2 = wr_en & (readRegister2 == writeRegister);
    // Read ports forward a same-cycle write; reserve effects are not forwarded.
    always_comb begin
        readData1 = byp1 ? writeData : regs_q[readRegister1];
        readData2 = byp2 ? writeData : regs_q[readRegister2];
        readBusy1 = byp1 ? 1'b0 : busy_q[readRegister1];
        readBusy2 = byp2 ? 1'b0 : busy_q[readRegister2];
    end
`else
    // Read ports return stored state only.
    always_comb begin
        readData1 = regs_q[readRegister1];
        readData2 = regs_q[readRegister2];
        readBusy1 = busy_q[readRegister1];
        readBusy2 = busy_q[readRegister2];
    end
`endif
endmodule
